// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the two-road traffic light controller:
// phase encodings, light patterns and the active-low 7-segment table.
// Optional macro NIGHT_FLASH_EN adds the FLASH state.
package traffic_light_pkg;

    localparam int LIGHT_W = 6;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        RED1  = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        RED2  = 3'd5
`ifdef NIGHT_FLASH_EN
        ,
        FLASH = 3'd6
`endif
    } state_e;

    // {A_R, A_Y, A_G, B_R, B_Y, B_G}
    localparam logic [LIGHT_W-1:0] LT_A_GRN   = 6'b001_100;
    localparam logic [LIGHT_W-1:0] LT_A_YEL   = 6'b010_100;
    localparam logic [LIGHT_W-1:0] LT_ALL_RED = 6'b100_100;
    localparam logic [LIGHT_W-1:0] LT_B_GRN   = 6'b100_001;
    localparam logic [LIGHT_W-1:0] LT_B_YEL   = 6'b100_010;
    localparam logic [LIGHT_W-1:0] LT_FLASH   = 6'b010_010;
    localparam logic [LIGHT_W-1:0] LT_OFF     = 6'b000_000;

    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    // Any value outside 0..9 decodes to a dark digit
    localparam logic [6:0] DIGIT_BLANK = 7'd10;

    // Segments {dp,g,f,e,d,c,b,a}, active-low
    function automatic logic [7:0] seg_lut(input logic [6:0] d);
        case (d)
            7'd0:    return 8'hC0;
            7'd1:    return 8'hF9;
            7'd2:    return 8'hA4;
            7'd3:    return 8'hB0;
            7'd4:    return 8'h99;
            7'd5:    return 8'h92;
            7'd6:    return 8'h82;
            7'd7:    return 8'hF8;
            7'd8:    return 8'h80;
            7'd9:    return 8'h90;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Steady light pattern per phase; unused codes look like all-red
    function automatic logic [LIGHT_W-1:0] light_of(input state_e s);
        case (s)
            A_GRN:   return LT_A_GRN;
            A_YEL:   return LT_A_YEL;
            B_GRN:   return LT_B_GRN;
            B_YEL:   return LT_B_YEL;
            default: return LT_ALL_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic light controller and its surroundings.
// Optional macro NIGHT_FLASH_EN adds the night input.
interface traffic_light_ctrl_if;
    import traffic_light_pkg::*;

    logic               ped_req;
`ifdef NIGHT_FLASH_EN
    logic               night;
`endif
    logic               clk_1Hz;
    logic [15:0]        total_state;
    logic [LIGHT_W-1:0] light;
    logic [3:0]         sm_wei;
    logic [7:0]         sm_duan;

`ifdef NIGHT_FLASH_EN
    modport master (output ped_req, night,
                    input  clk_1Hz, total_state, light, sm_wei, sm_duan);
    modport slave  (input  ped_req, night,
                    output clk_1Hz, total_state, light, sm_wei, sm_duan);
`else
    modport master (output ped_req,
                    input  clk_1Hz, total_state, light, sm_wei, sm_duan);
    modport slave  (input  ped_req,
                    output clk_1Hz, total_state, light, sm_wei, sm_duan);
`endif

endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver: two 0..99 values, split into
// tens/units, road A tens blanked when zero, one digit per SCAN_DIV cycles.
module seg7_scan
    import traffic_light_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] val_a,
    input  logic [6:0] val_b,
    input  logic       blank,
    output logic [3:0] sm_wei,
    output logic [7:0] sm_duan
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       slot_q, slot_d;
    logic [3:0]       sm_wei_q, sm_wei_d;
    logic [7:0]       sm_duan_q, sm_duan_d;
    logic [6:0]       digit;

    // Slot timer; select and segments are built from the next slot so both
    // outputs change on the same edge
    always_comb begin
        slot_d = slot_q;
        div_d  = div_q + DIV_W'(1);
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d  = '0;
            slot_d = slot_q + 2'd1;
        end
        case (slot_d)
            2'd0:    digit = (val_a < 7'd10) ? DIGIT_BLANK : val_a / 7'd10;
            2'd1:    digit = val_a % 7'd10;
            2'd2:    digit = val_b / 7'd10;
            default: digit = val_b % 7'd10;
        endcase
        sm_wei_d  = ~(4'b0001 << slot_d);
        sm_duan_d = blank ? SEG_BLANK : seg_lut(digit);
    end

    // Scan registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            slot_q    <= 2'd0;
            sm_wei_q  <= 4'b1110;
            sm_duan_q <= SEG_BLANK;
        end else begin
            div_q     <= div_d;
            slot_q    <= slot_d;
            sm_wei_q  <= sm_wei_d;
            sm_duan_q <= sm_duan_d;
        end
    end

    assign sm_wei  = sm_wei_q;
    assign sm_duan = sm_duan_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller: 1 Hz prescaler, six-phase sequencer
// with programmable durations, pedestrian green truncation and a per-road
// countdown display. Optional macro NIGHT_FLASH_EN adds night flashing.
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int SCAN_DIV  = 50000,
    parameter int GREEN_A_S = 30,
    parameter int GREEN_B_S = 20,
    parameter int YELLOW_S  = 3,
    parameter int ALL_RED_S = 2,
    parameter int PED_MIN_S = 5
) (
    input  logic                clk_50MHz,
    input  logic                reset,
    traffic_light_ctrl_if.slave bus
);

    localparam int               PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] PED_MIN = CNT_W'(PED_MIN_S);
    // Time still to wait after the current phase ends, per display case
    localparam logic [6:0] TAIL_R  = 7'(ALL_RED_S);
    localparam logic [6:0] TAIL_YR = 7'(YELLOW_S + ALL_RED_S);
    localparam logic [6:0] TAIL_GA = 7'(GREEN_A_S + YELLOW_S + ALL_RED_S);
    localparam logic [6:0] TAIL_GB = 7'(GREEN_B_S + YELLOW_S + ALL_RED_S);

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               clk_1hz_q, clk_1hz_d;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ped_lat_q, ped_lat_d;
    logic [LIGHT_W-1:0] light_q, light_d;
    logic               tick, in_green, ped_cut;
    logic [6:0]         c7, val_a, val_b;
    logic               blank;
    logic [3:0]         sm_wei;
    logic [7:0]         sm_duan;

    // Codes 6..7 (unreachable) behave as RED1
    function automatic state_e next_phase(input state_e s);
        case (s)
            A_GRN:   return A_YEL;
            A_YEL:   return RED1;
            B_GRN:   return B_YEL;
            B_YEL:   return RED2;
            RED2:    return A_GRN;
            default: return B_GRN;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] phase_len(input state_e s);
        case (s)
            A_GRN:        return CNT_W'(GREEN_A_S);
            B_GRN:        return CNT_W'(GREEN_B_S);
            A_YEL, B_YEL: return CNT_W'(YELLOW_S);
            default:      return CNT_W'(ALL_RED_S);
        endcase
    endfunction

    // Prescaler: tick on wrap, 1 Hz output high for the first half second
    always_comb begin
        tick      = (pre_q == PRE_W'(CLK_HZ - 1));
        pre_d     = tick ? '0 : pre_q + PRE_W'(1);
        clk_1hz_d = (pre_d < PRE_W'(CLK_HZ / 2));
    end

    // Phase sequencing, phase counter and pedestrian latch
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ped_lat_d = ped_lat_q | bus.ped_req;
        in_green  = (state_q == A_GRN) || (state_q == B_GRN);
        ped_cut   = in_green && ped_lat_d && (cnt_q > PED_MIN);
        if (tick) begin
            if (ped_cut) begin
                cnt_d = PED_MIN;
            end else if (cnt_q <= CNT_W'(1)) begin
                state_d = next_phase(state_q);
                cnt_d   = phase_len(state_d);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            // A request seen at a green tick is consumed even when green is
            // already short enough
            if (in_green) ped_lat_d = 1'b0;
        end
`ifdef NIGHT_FLASH_EN
        if (bus.night) begin
            state_d   = FLASH;
            cnt_d     = cnt_q;
            ped_lat_d = 1'b0;
        end else if (state_q == FLASH) begin
            state_d = RED1;
            cnt_d   = CNT_W'(ALL_RED_S);
        end
`endif
    end

    // Light pattern registered from the next state
    always_comb begin
        light_d = light_of(state_d);
`ifdef NIGHT_FLASH_EN
        if (state_d == FLASH) light_d = clk_1hz_d ? LT_FLASH : LT_OFF;
`endif
    end

    // Seconds until each road's light next changes
    always_comb begin
        c7    = cnt_q[6:0];
        blank = 1'b0;
        val_a = c7;
        val_b = c7;
        case (state_q)
            A_GRN:   val_b = c7 + TAIL_YR;
            A_YEL:   val_b = c7 + TAIL_R;
            B_GRN:   val_a = c7 + TAIL_YR;
            B_YEL:   val_a = c7 + TAIL_R;
            RED2:    val_b = c7 + TAIL_GA;
`ifdef NIGHT_FLASH_EN
            FLASH:   blank = 1'b1;
`endif
            default: val_a = c7 + TAIL_GB;
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            pre_q     <= '0;
            clk_1hz_q <= 1'b1;
            state_q   <= A_GRN;
            cnt_q     <= CNT_W'(GREEN_A_S);
            ped_lat_q <= 1'b0;
            light_q   <= LT_A_GRN;
        end else begin
            pre_q     <= pre_d;
            clk_1hz_q <= clk_1hz_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ped_lat_q <= ped_lat_d;
            light_q   <= light_d;
        end
    end

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk_50MHz),
        .rst     (reset),
        .val_a   (val_a),
        .val_b   (val_b),
        .blank   (blank),
        .sm_wei  (sm_wei),
        .sm_duan (sm_duan)
    );

    assign bus.clk_1Hz     = clk_1hz_q;
    assign bus.total_state = {5'b0, state_q, cnt_q};
    assign bus.light       = light_q;
    assign bus.sm_wei      = sm_wei;
    assign bus.sm_duan     = sm_duan;

endmodule
